// File: rtl/btn_conditioner.sv
// Button front end: 2-FF sync + debounce per channel, edge pulses, game tick, optional hold meter.
// Latency: a level change is accepted DEBOUNCE_CYCLES+2 cycles after the raw change; pulses are 1 cycle.
// Backpressure: none; all outputs are free-running pulses/levels. Build option: HOLD_METER_EN.
module btn_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int TICK_DIV        = 300_000,
  parameter int HOLD_W          = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_raw,
  input  logic              press_raw,
  output logic              start_lvl,
  output logic              start_rise,
  output logic              press_lvl,
  output logic              press_rise,
  output logic              press_fall,
  output logic              tick,
  output logic [HOLD_W-1:0] hold_ticks,
  output logic              hold_valid
);

  // Counter widths sized to the largest value each counter can hold.
  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int TK_W = $clog2(TICK_DIV);
  localparam logic [DB_W-1:0] DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TK_W-1:0] TK_LAST  = TK_W'(TICK_DIV - 1);
  localparam logic [TK_W-1:0] TK_PULSE = TK_W'(1);

  logic [1:0] raw;
  assign raw = {press_raw, start_raw};

  // Channel 0 = start, channel 1 = press; the two channels never interact.
  for (genvar i = 0; i < 2; i++) begin : g_ch
    logic            sync1;
    logic            sync2;
    logic            lvl;
    logic            lvl_d;
    logic [DB_W-1:0] cnt;

    // Synchronise raw input, then accept a new level only after it stays stable long enough.
    always_ff @(posedge clk) begin
      if (rst) begin
        sync1 <= 1'b0;
        sync2 <= 1'b0;
        lvl   <= 1'b0;
        lvl_d <= 1'b0;
        cnt   <= '0;
      end else begin
        sync1 <= raw[i];
        sync2 <= sync1;
        lvl_d <= lvl;
        if (sync2 == lvl) begin
          cnt <= '0;
        end else if (cnt == DB_LAST) begin
          lvl <= sync2;
          cnt <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

  assign start_lvl  = g_ch[0].lvl;
  assign start_rise = g_ch[0].lvl & ~g_ch[0].lvl_d;
  assign press_lvl  = g_ch[1].lvl;
  assign press_rise = g_ch[1].lvl & ~g_ch[1].lvl_d;
  assign press_fall = ~g_ch[1].lvl & g_ch[1].lvl_d;

  logic [TK_W-1:0] tcnt;

  // Free-running tick divider; the pulse sits on count 1 so the first tick follows reset by one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      tcnt <= '0;
    end else if (tcnt == TK_LAST) begin
      tcnt <= '0;
    end else begin
      tcnt <= tcnt + 1'b1;
    end
  end

  assign tick = (tcnt == TK_PULSE);

`ifdef HOLD_METER_EN
  logic [HOLD_W-1:0] hcnt;
  logic [HOLD_W-1:0] hold_q;
  logic              hold_vld_q;

  // Count ticks while the press is held (the rise cycle only clears), latch the count on release.
  always_ff @(posedge clk) begin
    if (rst) begin
      hcnt       <= '0;
      hold_q     <= '0;
      hold_vld_q <= 1'b0;
    end else begin
      hold_vld_q <= press_fall;
      if (press_rise) begin
        hcnt <= '0;
      end else if (press_lvl && tick && (hcnt != {HOLD_W{1'b1}})) begin
        hcnt <= hcnt + 1'b1;
      end
      if (press_fall) begin
        hold_q <= hcnt;
      end
    end
  end

  assign hold_ticks = hold_q;
  assign hold_valid = hold_vld_q;
`else
  assign hold_ticks = '0;
  assign hold_valid = 1'b0;
`endif

endmodule

// File: tb/tb_btn_conditioner.sv
// Bench for btn_conditioner with DEBOUNCE_CYCLES=4, TICK_DIV=10, HOLD_W=4.
// Expected pulses are queued with their cycle stamp when stimulus is driven; a negedge monitor pops them.
// Build with or without HOLD_METER_EN; the hold expectations follow the same macro.
module tb_btn_conditioner;

  localparam int DB  = 4;
  localparam int TD  = 10;
  localparam int HW  = 4;
  localparam int SAT = (1 << HW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start_raw = 1'b0;
  logic          press_raw = 1'b0;
  logic          start_lvl, start_rise, press_lvl, press_rise, press_fall, tick, hold_valid;
  logic [HW-1:0] hold_ticks;

  btn_conditioner #(.DEBOUNCE_CYCLES(DB), .TICK_DIV(TD), .HOLD_W(HW)) dut (
    .clk        (clk),
    .rst        (rst),
    .start_raw  (start_raw),
    .press_raw  (press_raw),
    .start_lvl  (start_lvl),
    .start_rise (start_rise),
    .press_lvl  (press_lvl),
    .press_rise (press_rise),
    .press_fall (press_fall),
    .tick       (tick),
    .hold_ticks (hold_ticks),
    .hold_valid (hold_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    int val;
  } ev_t;

  ev_t q_srise[$];
  ev_t q_prise[$];
  ev_t q_pfall[$];
  ev_t q_hval[$];

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  int cur_hold = 0;
  bit mon_en = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
  endtask

  // Cycles since reset release; cycle 1 is the one after the first non-reset edge.
  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  // Monitor: tick pattern every cycle, pulses against the scoreboard queues.
  always @(negedge clk) begin
    ev_t ev;
    if (mon_en) begin
      check("tick", {31'd0, tick}, (cyc % TD == 1) ? 32'd1 : 32'd0);
      if (start_rise) begin
        if (q_srise.size() == 0) check("start_rise_extra", 1, 0);
        else begin ev = q_srise.pop_front(); check("start_rise_cyc", cyc, ev.cyc); end
      end
      if (press_rise) begin
        if (q_prise.size() == 0) check("press_rise_extra", 1, 0);
        else begin ev = q_prise.pop_front(); check("press_rise_cyc", cyc, ev.cyc); end
      end
      if (press_fall) begin
        if (q_pfall.size() == 0) check("press_fall_extra", 1, 0);
        else begin ev = q_pfall.pop_front(); check("press_fall_cyc", cyc, ev.cyc); end
      end
      if (hold_valid) begin
        if (q_hval.size() == 0) check("hold_valid_extra", 1, 0);
        else begin
          ev = q_hval.pop_front();
          check("hold_valid_cyc", cyc, ev.cyc);
          check("hold_ticks_val", {28'd0, hold_ticks}, ev.val);
        end
      end
`ifndef HOLD_METER_EN
      check("hold_ticks_tied", {28'd0, hold_ticks}, 0);
`endif
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drained(input string tag);
    check({tag, "_srise_pending"}, q_srise.size(), 0);
    check({tag, "_prise_pending"}, q_prise.size(), 0);
    check({tag, "_pfall_pending"}, q_pfall.size(), 0);
    check({tag, "_hval_pending"},  q_hval.size(),  0);
  endtask

  task automatic push(inout ev_t q[$], input int c, input int v);
    ev_t e;
    e.cyc = c;
    e.val = v;
    q.push_back(e);
  endtask

  // Ticks seen strictly after the rise cycle and before the fall cycle, saturated.
  function automatic int hold_expect(input int r, input int f);
    int n = 0;
    for (int t = r + 1; t < f; t++) if (t % TD == 1) n++;
    return (n > SAT) ? SAT : n;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    mon_en   = 1'b1;
    cur_hold = 0;
    check("reset_outputs", {start_lvl, start_rise, press_lvl, press_rise, press_fall, tick, hold_valid, hold_ticks}, 0);
    rst = 1'b0;
    @(negedge clk);
    check("release_cycle_outputs", {start_lvl, start_rise, press_lvl, press_rise, press_fall, tick, hold_valid, hold_ticks}, 0);
    @(posedge clk);
    #1;
  endtask

  // Releases the press during the current cycle; r is the cycle the rise was expected in.
  task automatic release_press(input int r);
    int f;
    f = cyc + DB + 2;
    press_raw = 1'b0;
    push(q_pfall, f, 0);
`ifdef HOLD_METER_EN
    cur_hold = hold_expect(r, f);
    push(q_hval, f + 1, cur_hold);
`endif
    wait_cyc(DB + 6);
  endtask

  // Holds press_raw for len cycles (len >= 8).
  task automatic press(input int len);
    int r;
    r = cyc + DB + 2;
    press_raw = 1'b1;
    push(q_prise, r, 0);
    wait_cyc(DB + 3);
    check("press_lvl_held", {31'd0, press_lvl}, 1);
    wait_cyc(len - (DB + 3));
    release_press(r);
  endtask

  initial begin
    do_reset();

    // Idle: only ticks at 1, 11, 21.
    wait_cyc(25);
    check("idle_press_lvl", {31'd0, press_lvl}, 0);
    drained("idle");

    // Both channels together; start stays held across the press.
    begin
      int r;
      r = cyc + DB + 2;
      start_raw = 1'b1;
      press_raw = 1'b1;
      push(q_srise, r, 0);
      push(q_prise, r, 0);
      wait_cyc(DB + 1);
      check("press_lvl_before_accept", {31'd0, press_lvl}, 0);
      wait_cyc(5);
      check("press_lvl_accepted", {31'd0, press_lvl}, 1);
      check("start_lvl_accepted", {31'd0, start_lvl}, 1);
      release_press(r);
      check("start_lvl_indep", {31'd0, start_lvl}, 1);
      start_raw = 1'b0;
      wait_cyc(DB + 6);
      check("start_lvl_released", {31'd0, start_lvl}, 0);
      drained("dual");
      check("hold_after_dual", {28'd0, hold_ticks}, cur_hold);
    end

    // Bounce: 3 cycles high is shorter than the debounce window.
    press_raw = 1'b1;
    wait_cyc(3);
    press_raw = 1'b0;
    wait_cyc(12);
    check("bounce_press_lvl", {31'd0, press_lvl}, 0);
    drained("bounce");
    check("hold_after_bounce", {28'd0, hold_ticks}, cur_hold);

    // Clean 35-cycle press whose rise lands on a tick cycle.
    while (cyc % TD != 5) wait_cyc(1);
    press(35);
    drained("clean");
`ifdef HOLD_METER_EN
    check("clean_hold", {28'd0, hold_ticks}, 3);
`else
    check("clean_hold_tied", {28'd0, hold_ticks}, 0);
`endif

    // Long press saturates.
    press(200);
    drained("long");
`ifdef HOLD_METER_EN
    check("long_hold_sat", {28'd0, hold_ticks}, SAT);
`else
    check("long_hold_tied", {28'd0, hold_ticks}, 0);
`endif

    // Reset mid-debounce (cnt=2) with raw held: no pulses, re-accepted 6 cycles after release.
    press_raw = 1'b1;
    wait_cyc(4);
    check("midrst_press_lvl", {31'd0, press_lvl}, 0);
    do_reset();
    push(q_prise, DB + 2, 0);
    wait_cyc(DB + 3);
    check("midrst_press_lvl_after", {31'd0, press_lvl}, 1);
    check("midrst_hold_cleared", {28'd0, hold_ticks}, 0);
    wait_cyc(20);
    release_press(DB + 2);
    drained("midrst");
    check("midrst_final_hold", {28'd0, hold_ticks}, cur_hold);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
